lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/toothless_pkg.sv | 24 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_ctrl.sv | 132 +++++++++++++
 tb/tb_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toothless_pkg.sv
// ---------------------------------------------------------------------------
// toothless_pkg
// Shared types for the load/store unit:
//   lsu_state_e : LSU bus-transaction FSM states
//   data_type_e : access size, encoded exactly as the decoder's type_i field
//                 (2'b11 is the illegal encoding and has no enum member)
// ---------------------------------------------------------------------------
package toothless_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        REQ         = 2'b01,
        WAIT_RVALID = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        DT_BYTE = 2'b00,
        DT_HALF = 2'b01,
        DT_WORD = 2'b10
    } data_type_e;

    localparam logic [1:0] TYPE_ILLEGAL = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational data steering between the core and a 32-bit,
// word-addressed memory port.
//   addr_lo_i : byte offset within the word (addr[1:0])
//   type_i    : access size
//   uns_i     : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i   : store data from the register file
//   rdata_i   : raw word returned by memory
//   be_o      : byte enables for the memory request
//   wdata_o   : store data replicated into every lane
//   rdata_o   : load data shifted down to bit 0 and extended
// Halfword accesses only look at addr_lo_i[1] and word accesses ignore the
// offset entirely, so misaligned accesses naturally round down.
// ---------------------------------------------------------------------------
module lsu_align
    import toothless_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  data_type_e  type_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        shifted = rdata_i;
        rdata_o = rdata_i;
        case (type_i)
            DT_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                shifted = rdata_i >> {addr_lo_i, 3'b000};
                rdata_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
            end
            DT_HALF: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                shifted = rdata_i >> {addr_lo_i[1], 4'b0000};
                rdata_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller: accepts one decoder memory request at a time,
// issues it on a req/gnt/rvalid memory port and returns aligned load data.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_i, we_i       : request strobe (held while stall_o), 1 = store
//   type_i, uns_i     : access size (2'b11 illegal), zero-extend loads
//   addr_i, wdata_i   : effective byte address, store data
//   stall_o           : hold the pipeline
//   rvalid_o, rdata_o : completion strobe, aligned/extended load data
//   err_o             : one-cycle strobe for a rejected request
//   data_*_o          : memory request channel
//   data_gnt_i, data_rvalid_i, data_rdata_i : memory grant/response channel
//
// Build option
//   LSU_MISALIGN_CHECK_EN : when defined, misaligned halfword/word accesses
//   are rejected with err_o instead of being rounded down.
// ---------------------------------------------------------------------------
module lsu_ctrl
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            type_i,
    input  logic                  uns_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  data_req_o,
    output logic                  data_we_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    lsu_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    data_type_e            type_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  req_legal;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        req_legal = (type_i != TYPE_ILLEGAL);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((type_i == DT_HALF && addr_i[0]) ||
            (type_i == DT_WORD && addr_i[1:0] != 2'b00)) begin
            req_legal = 1'b0;
        end
`endif
    end

    // Captured fields stay frozen from acceptance until the response, so the
    // bus request is stable while waiting for grant.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            type_q  <= DT_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && req_legal) begin
                        addr_q  <= addr_i;
                        we_q    <= we_i;
                        type_q  <= data_type_e'(type_i);
                        uns_q   <= uns_i;
                        wdata_q <= wdata_i;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    lsu_align u_align (
        .addr_lo_i (addr_q[1:0]),
        .type_i    (type_q),
        .uns_i     (uns_q),
        .wdata_i   (wdata_q),
        .rdata_i   (data_rdata_i),
        .be_o      (data_be_o),
        .wdata_o   (data_wdata_o),
        .rdata_o   (ld_data)
    );

    // Memory port is word addressed; the byte offset lives in data_be_o.
    assign data_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign data_req_o  = (state_q == REQ);
    assign data_we_o   = we_q;

    // Response strobe is combinational from data_rvalid_i; gnt/rvalid in any
    // other state are ignored by construction.
    assign rvalid_o = (state_q == WAIT_RVALID) && data_rvalid_i;
    assign rdata_o  = (rvalid_o && !we_q) ? ld_data : '0;

    // The IDLE terms depend on req_i directly, so they are qualified with
    // rst_n to keep both strobes low while reset is held.
    assign stall_o = rst_n && (((state_q == IDLE) && req_i && req_legal) ||
                               (state_q == REQ) ||
                               ((state_q == WAIT_RVALID) && !data_rvalid_i));
    assign err_o   = rst_n && (state_q == IDLE) && req_i && !req_legal;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Table-driven bench for lsu_ctrl: each vector is one complete transaction
// with hand-computed bus fields and load result, followed by hand-written
// sequences for reset, ignored handshakes and mid-transaction reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, we_i, uns_i;
    logic [1:0]  type_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .we_i          (we_i),
        .type_i        (type_i),
        .uns_i         (uns_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .data_req_o    (data_req_o),
        .data_we_o     (data_we_o),
        .data_addr_o   (data_addr_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] typ, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gnt_dly, input logic exp_err,
                                input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.typ = typ; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.gnt_dly = gnt_dly; v.exp_err = exp_err;
        v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic idle_inputs();
        req_i = 1'b0; we_i = 1'b0; type_i = 2'b00; uns_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stall_cnt;
        string tag;
        tag = $sformatf("v%0d", idx);
        stall_cnt = 0;

        // Acceptance cycle (IDLE)
        @(negedge clk);
        req_i = 1'b1; we_i = v.we; type_i = v.typ; uns_i = v.uns;
        addr_i = v.addr; wdata_i = v.wdata;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = v.rdata;
        #1;
        if (v.exp_err) begin
            check({tag, " err_o"}, 32'(err_o), 32'd1);
            check({tag, " stall_on_err"}, 32'(stall_o), 32'd0);
            check({tag, " req_on_err"}, 32'(data_req_o), 32'd0);
            @(negedge clk);
            req_i = 1'b0;
            #1;
            check({tag, " req_after_err"}, 32'(data_req_o), 32'd0);
            check({tag, " err_pulse_end"}, 32'(err_o), 32'd0);
            return;
        end
        check({tag, " err_o"}, 32'(err_o), 32'd0);
        check({tag, " accept_req"}, 32'(data_req_o), 32'd0);
        if (stall_o) stall_cnt++;

        // REQ cycles: grant withheld for gnt_dly cycles, fields must hold
        for (int c = 0; c <= v.gnt_dly; c++) begin
            @(negedge clk);
            data_gnt_i = (c == v.gnt_dly);
            #1;
            check($sformatf("%s req_c%0d", tag, c), 32'(data_req_o), 32'd1);
            check($sformatf("%s addr_c%0d", tag, c), data_addr_o, v.exp_addr);
            check($sformatf("%s be_c%0d", tag, c), 32'(data_be_o), 32'(v.exp_be));
            check($sformatf("%s wdata_c%0d", tag, c), data_wdata_o, v.exp_wdata);
            check($sformatf("%s we_c%0d", tag, c), 32'(data_we_o), 32'(v.we));
            check($sformatf("%s rvalid_c%0d", tag, c), 32'(rvalid_o), 32'd0);
            if (stall_o) stall_cnt++;
        end

        // WAIT_RVALID with response present
        @(negedge clk);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        #1;
        check({tag, " req_in_wait"}, 32'(data_req_o), 32'd0);
        check({tag, " rvalid_o"}, 32'(rvalid_o), 32'd1);
        check({tag, " rdata_o"}, rdata_o, v.exp_rdata);
        if (stall_o) stall_cnt++;
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.gnt_dly + 2));

        // Back in IDLE: stray rvalid is ignored
        @(negedge clk);
        req_i = 1'b0;
        #1;
        check({tag, " rvalid_after"}, 32'(rvalid_o), 32'd0);
        check({tag, " rdata_after"}, rdata_o, 32'd0);
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        // we typ uns addr wdata rdata dly err exp_addr be exp_wdata exp_rdata
        vecs[0]  = mk(0, 2'b10, 0, 32'h100, 32'h1111_1111, 32'hDEAD_BEEF, 0, 0, 32'h100, 4'b1111, 32'h1111_1111, 32'hDEAD_BEEF);
        vecs[1]  = mk(0, 2'b00, 0, 32'h103, 32'h0000_005A, 32'h8012_3456, 0, 0, 32'h100, 4'b1000, 32'h5A5A_5A5A, 32'hFFFF_FF80);
        vecs[2]  = mk(0, 2'b00, 1, 32'h103, 32'h0000_005A, 32'h8012_3456, 0, 0, 32'h100, 4'b1000, 32'h5A5A_5A5A, 32'h0000_0080);
        vecs[3]  = mk(1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 32'h55AA_55AA, 3, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000);
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[4]  = mk(0, 2'b10, 0, 32'h101, 32'h0,         32'hCAFE_BABE, 0, 1, 32'h0,   4'b0000, 32'h0,         32'h0);
`else
        vecs[4]  = mk(0, 2'b10, 0, 32'h101, 32'h0,         32'hCAFE_BABE, 0, 0, 32'h100, 4'b1111, 32'h0,         32'hCAFE_BABE);
`endif
        vecs[5]  = mk(0, 2'b11, 0, 32'h040, 32'h0,         32'h0,         0, 1, 32'h0,   4'b0000, 32'h0,         32'h0);
        vecs[6]  = mk(0, 2'b01, 0, 32'h206, 32'h0,         32'h8001_7FFF, 0, 0, 32'h204, 4'b1100, 32'h0,         32'hFFFF_8001);
        vecs[7]  = mk(0, 2'b00, 0, 32'h001, 32'h0,         32'h0000_7F00, 0, 0, 32'h000, 4'b0010, 32'h0,         32'h0000_007F);
        vecs[8]  = mk(1, 2'b00, 0, 32'h003, 32'h0000_00A5, 32'h0,         1, 0, 32'h000, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0000);
        vecs[9]  = mk(0, 2'b01, 1, 32'h200, 32'h0,         32'h1234_F00D, 0, 0, 32'h200, 4'b0011, 32'h0,         32'h0000_F00D);
        vecs[10] = mk(1, 2'b10, 0, 32'h010, 32'hCAFE_F00D, 32'h1234_5678, 2, 0, 32'h010, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000);
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[11] = mk(0, 2'b01, 0, 32'h203, 32'h0,         32'h8001_7FFF, 0, 1, 32'h0,   4'b0000, 32'h0,         32'h0);
`else
        vecs[11] = mk(0, 2'b01, 0, 32'h203, 32'h0,         32'h8001_7FFF, 0, 0, 32'h200, 4'b1100, 32'h0,         32'hFFFF_8001);
`endif

        // Reset state, with handshakes asserted to show they are ignored
        idle_inputs();
        rst_n = 1'b0;
        #12;
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
        #1;
        check("rst stall_o", 32'(stall_o), 32'd0);
        check("rst data_req_o", 32'(data_req_o), 32'd0);
        check("rst rvalid_o", 32'(rvalid_o), 32'd0);
        check("rst err_o", 32'(err_o), 32'd0);
        check("rst data_addr_o", data_addr_o, 32'd0);
        check("rst data_we_o", 32'(data_we_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray gnt/rvalid in IDLE without a request
        @(negedge clk);
        #1;
        check("idle_stray rvalid_o", 32'(rvalid_o), 32'd0);
        check("idle_stray rdata_o", rdata_o, 32'd0);
        check("idle_stray stall_o", 32'(stall_o), 32'd0);
        @(negedge clk);
        #1;
        check("idle_stray data_req_o", 32'(data_req_o), 32'd0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while waiting for the response, then a late rvalid
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; type_i = 2'b10; uns_i = 1'b0;
        addr_i = 32'h300; wdata_i = '0; data_rdata_i = 32'h1234_5678;
        @(negedge clk);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        #1;
        check("midrst pre stall_o", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        req_i = 1'b0;
        #1;
        check("midrst stall_o", 32'(stall_o), 32'd0);
        check("midrst data_req_o", 32'(data_req_o), 32'd0);
        check("midrst data_addr_o", data_addr_o, 32'd0);
        data_rvalid_i = 1'b1;
        #1;
        check("midrst rvalid_o", 32'(rvalid_o), 32'd0);
        check("midrst rdata_o", rdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("postrst rvalid_o", 32'(rvalid_o), 32'd0);
        check("postrst stall_o", 32'(stall_o), 32'd0);
        check("postrst data_req_o", 32'(data_req_o), 32'd0);
        data_rvalid_i = 1'b0;

        // The unit accepts a fresh request after the abandoned one
        run_vec(vecs[0], 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
